// File: rtl/gptp_pkg.sv
// Shared widths, timestamp field layout and scheduler state encoding for the gPTP send path.
package gptp_pkg;

  localparam int GPTP_FRAME_W = 352;
  localparam int GPTP_TS_W    = 80;

  // Timestamp layout: {epoch[15:0], sec[31:0], nanosec[31:0]}
  localparam int TS_NS_LSB    = 0;
  localparam int TS_NS_W      = 32;
  localparam int TS_SEC_LSB   = 32;
  localparam int TS_SEC_W     = 32;
  localparam int TS_EPOCH_LSB = 64;
  localparam int TS_EPOCH_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_TS = 2'd2,
    ST_GAP     = 2'd3
  } gptp_state_e;

  function automatic logic [GPTP_TS_W-1:0] ts_pack(
    input logic [TS_EPOCH_W-1:0] epoch,
    input logic [TS_SEC_W-1:0]   sec,
    input logic [TS_NS_W-1:0]    ns
  );
    return {epoch, sec, ns};
  endfunction

endpackage

// File: rtl/gptp_tx_sched_if.sv
// Requester, send and timestamp signals of gptp_tx_sched; master = scheduler, slave = environment.
// Handshake: req_ready pulses in the capture cycle; tx moves on tx_valid && tx_ready; ts/done are strobes.
interface gptp_tx_sched_if #(parameter int N = 4);
  import gptp_pkg::*;

  logic [N-1:0]              req_valid;
  logic [N*GPTP_FRAME_W-1:0] req_data;
  logic [N-1:0]              req_ready;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [GPTP_FRAME_W-1:0]   tx_data;
  logic                      ts_valid;
  logic [GPTP_TS_W-1:0]      ts_data;
  logic [N-1:0]              done_valid;
  logic [GPTP_TS_W-1:0]      done_ts;
  logic                      done_err;
  logic                      busy;
  logic [2:0]                grant_id;
  logic [15:0]               stray_cnt;
  gptp_state_e               fsm_state;

  modport master (
    input  req_valid, req_data, tx_ready, ts_valid, ts_data,
    output req_ready, tx_valid, tx_data, done_valid, done_ts, done_err,
           busy, grant_id, stray_cnt, fsm_state
  );

  modport slave (
    output req_valid, req_data, tx_ready, ts_valid, ts_data,
    input  req_ready, tx_valid, tx_data, done_valid, done_ts, done_err,
           busy, grant_id, stray_cnt, fsm_state
  );

endinterface

// File: rtl/gptp_rr_arbiter.sv
// One-hot grant plus index from N request bits. GPTP_TXSCHED_RR_EN selects round-robin
// starting after ptr; otherwise lowest index wins and there is no pointer input.
module gptp_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
`ifdef GPTP_TXSCHED_RR_EN
  input  logic [2:0]   ptr,
`endif
  output logic [N-1:0] gnt,
  output logic [2:0]   idx
);

`ifdef GPTP_TXSCHED_RR_EN
  logic [3:0]   sh;
  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;
  logic [3:0]   pos;
  logic [3:0]   sum;

  // Rotate so the slot after ptr sits at bit 0, pick the lowest, rotate back.
  always_comb begin
    sh     = {1'b0, ptr} + 4'd1;
    rot    = N'({req, req} >> sh);
    rot_oh = '0;
    pos    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rot_oh    = '0;
        rot_oh[k] = 1'b1;
        pos       = 4'(k);
      end
    end
    gnt = N'(({rot_oh, rot_oh} << sh) >> N);
    sum = pos + sh;
    if (sum >= 4'(N)) sum = sum - 4'(N);
    idx = (|req) ? sum[2:0] : 3'd0;
  end
`else
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = 3'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/gptp_tx_sched.sv
// gPTP transmit scheduler: grants one requester, forwards its frame, routes the egress
// timestamp (or a timeout error) back. Round-robin when GPTP_TXSCHED_RR_EN is defined.
module gptp_tx_sched
  import gptp_pkg::*;
#(
  parameter int N          = 4,
  parameter int TS_TIMEOUT = 64,
  parameter int IFG        = 8
) (
  input logic               clk_sd,
  input logic               reset,
  gptp_tx_sched_if.master   bus
);

  localparam int TW = $clog2(TS_TIMEOUT + 1);
  localparam int GW = $clog2(IFG + 2);
  localparam logic [TW-1:0] T_LAST = TW'(TS_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'((IFG == 0) ? 0 : IFG - 1);

  gptp_state_e state, state_n;

  logic [N-1:0]            arb_gnt;
  logic [2:0]              arb_idx;
  logic [GPTP_FRAME_W-1:0] sel_data;
  logic [TW-1:0]           tcnt;
  logic [GW-1:0]           gcnt;
  logic                    grab;
  logic                    xfer;
  logic                    fin_ok;
  logic                    fin_err;

`ifdef GPTP_TXSCHED_RR_EN
  logic [2:0] rr_ptr;

  always_ff @(posedge clk_sd) begin
    if (!reset)    rr_ptr <= 3'(N - 1);
    else if (grab) rr_ptr <= arb_idx;
  end

  gptp_rr_arbiter #(.N(N)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );
`else
  gptp_rr_arbiter #(.N(N)) u_arb (
    .req (bus.req_valid),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) sel_data = bus.req_data[i*GPTP_FRAME_W +: GPTP_FRAME_W];
    end
  end

  always_ff @(posedge clk_sd) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // req_ready is gated by reset so no capture is signalled while the block is held.
  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    grab          = 1'b0;
    xfer          = 1'b0;
    fin_ok        = 1'b0;
    fin_err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reset && (|bus.req_valid)) begin
          bus.req_ready = arb_gnt;
          grab          = 1'b1;
          state_n       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_valid && bus.tx_ready) begin
          xfer    = 1'b1;
          state_n = ST_WAIT_TS;
        end
      end
      ST_WAIT_TS: begin
        if (bus.ts_valid) begin
          fin_ok  = 1'b1;
          state_n = ST_GAP;
        end else if (tcnt == T_LAST) begin
          fin_err = 1'b1;
          state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gcnt == G_LAST) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sd) begin
    if (!reset) begin
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= '0;
      bus.done_valid <= '0;
      bus.done_ts    <= '0;
      bus.done_err   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.grant_id   <= '0;
      bus.stray_cnt  <= '0;
      tcnt           <= '0;
      gcnt           <= '0;
    end else begin
      bus.done_valid <= '0;
      bus.done_err   <= 1'b0;
      bus.busy       <= (state_n != ST_IDLE);
      if (grab) begin
        bus.tx_data  <= sel_data;
        bus.grant_id <= arb_idx;
        bus.tx_valid <= 1'b1;
      end
      if (xfer) begin
        bus.tx_valid <= 1'b0;
        tcnt         <= '0;
      end
      if (state == ST_WAIT_TS) tcnt <= tcnt + TW'(1);
      if (fin_ok || fin_err) begin
        bus.done_valid <= N'(1) << bus.grant_id;
        bus.done_ts    <= fin_ok ? bus.ts_data : '0;
        bus.done_err   <= fin_err;
        gcnt           <= '0;
      end
      if (state == ST_GAP) gcnt <= gcnt + GW'(1);
      if (bus.ts_valid && (state != ST_WAIT_TS) && (bus.stray_cnt != 16'hFFFF))
        bus.stray_cnt <= bus.stray_cnt + 16'd1;
    end
  end

  assign bus.fsm_state = state;

endmodule
